fetch_mem_arbiter: RTL and testbench

Shares the single unified instruction/data memory between instruction fetch and the MEM stage. It replaces the clock-divided IM/DM multiplexing scheme with a pipelined one-request-per-cycle arbiter and a parametrised instruction prefetch queue. The block sits between the IF/ID register, the EX/MEM stage and `Memory`. Data accesses have priority; fetches use every free memory cycle.

---
 rtl/fetch_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one unified memory between fetch and MEM.
// One request per cycle, data first, fetches fill a prefetch queue.
//
// Ports
//   CLK, RST            clock, synchronous active-low reset
//   redirect_valid/pc   flush the queue and restart fetch at redirect_pc
//   fetch_halt          stop issuing new fetches
//   fetch_stall         decode is not consuming the queue head
//   if_valid/instr/pc   queue head (NOP / 0 when empty)
//   dmem_*              MEM-stage access; dmem_ack pulses one cycle later
//   mem_*               unified memory port, read data one cycle later
module fetch_mem_arbiter #(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0033
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_halt,
  input  logic            fetch_stall,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_funct3,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [31:0]     dmem_wdata,
  output logic            dmem_ack,
  output logic [31:0]     dmem_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [2:0]      mem_funct3,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam int PW = $clog2(FQ_DEPTH);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FETCH,
    RSP_DATA
  } rsp_t;

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [31:0]     q_instr [FQ_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW:0]     count;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  rsp_t            rsp_state;
  rsp_t            rsp_next;
  logic            kill;

  logic            data_ok;
  logic            fetch_ok;
  logic            issue_data;
  logic            issue_fetch;
  logic            push;
  logic            pop;
  logic [PW+1:0]   occ;

  // Queued entries plus the fetch whose data lands next cycle.
  assign occ = {1'b0, count}
             + {{(PW+1){1'b0}}, rsp_state == RSP_FETCH};

  assign data_ok  = dmem_req && (rsp_state != RSP_DATA);
  assign fetch_ok = !fetch_halt && !redirect_valid
                 && (occ < (PW+2)'(FQ_DEPTH));

  assign issue_data  = RST && data_ok;
  assign issue_fetch = RST && !data_ok && fetch_ok;

  always_comb begin
    rsp_next   = RSP_NONE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b010;
    mem_addr   = fetch_pc;
    mem_wdata  = '0;
    unique case (1'b1)
      issue_data: begin
        rsp_next   = RSP_DATA;
        mem_en     = 1'b1;
        mem_we     = dmem_we;
        mem_funct3 = dmem_funct3;
        mem_addr   = dmem_addr;
        mem_wdata  = dmem_wdata;
      end
      issue_fetch: begin
        rsp_next = RSP_FETCH;
        mem_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign push = (rsp_state == RSP_FETCH) && !kill;
  assign pop  = if_valid && !fetch_stall;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_pc  <= RESET_PC;
      rsp_state <= RSP_NONE;
      rsp_pc    <= '0;
      kill      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
    end else begin
      rsp_state <= rsp_next;
      kill      <= redirect_valid;
      if (issue_fetch) begin
        rsp_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !redirect_valid) begin
      q_pc[wptr]    <= rsp_pc;
      q_instr[wptr] <= mem_rdata;
    end
  end

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? q_instr[rptr] : NOP;
  assign if_pc    = if_valid ? q_pc[rptr] : '0;

  // Reset drops an outstanding data response immediately.
  assign dmem_ack   = RST && (rsp_state == RSP_DATA);
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: directed bench for fetch_mem_arbiter.
// Unified memory model holds 32'h1000_0000 + i at address 4*i.
module tb_fetch_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_halt;
  logic        fetch_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  fetch_mem_arbiter dut (
    .CLK(CLK),
    .RST(RST),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_halt(fetch_halt),
    .fetch_stall(fetch_stall),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_funct3(dmem_funct3),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_funct3(mem_funct3),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[64]        = 32'hDEAD_BEEF;
    mem_rdata      = '0;
    RST            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_halt     = 1'b0;
    fetch_stall    = 1'b1;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_funct3    = 3'b010;
    dmem_addr      = '0;
    dmem_wdata     = '0;

    repeat (3) begin
      cyc(); #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_instr", if_instr, 32'h33);
      chk("rst_valid", 32'(if_valid), 32'd0);
    end

    RST = 1'b1; #1;
    chk("c0_en", 32'(mem_en), 32'd1);
    chk("c0_addr", mem_addr, 32'h0);
    chk("c0_f3", 32'(mem_funct3), 32'd2);
    cyc(); #1;
    chk("c1_addr", mem_addr, 32'h4);
    chk("c1_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    chk("c2_addr", mem_addr, 32'h8);
    chk("c2_valid", 32'(if_valid), 32'd1);
    chk("c2_pc", if_pc, 32'h0);
    chk("c2_instr", if_instr, 32'h1000_0000);
    cyc(); #1;
    chk("c3_addr", mem_addr, 32'hC);
    cyc(); #1;
    chk("c4_full_en", 32'(mem_en), 32'd0);
    cyc(); #1;
    chk("c5_full_en", 32'(mem_en), 32'd0);
    chk("c5_pc", if_pc, 32'h0);

    cyc(); fetch_stall = 1'b0; #1;
    chk("c6_en", 32'(mem_en), 32'd0);
    chk("c6_pc", if_pc, 32'h0);
    cyc(); #1;
    chk("c7_pc", if_pc, 32'h4);
    chk("c7_addr", mem_addr, 32'h10);
    cyc(); #1;
    chk("c8_pc", if_pc, 32'h8);
    cyc(); #1;
    chk("c9_pc", if_pc, 32'hC);
    cyc(); #1;
    chk("c10_wrap_pc", if_pc, 32'h10);
    chk("c10_wrap_instr", if_instr, 32'h1000_0004);
    chk("c10_addr", mem_addr, 32'h1C);

    cyc();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h100;
    #1;
    chk("ld_issue_en", 32'(mem_en), 32'd1);
    chk("ld_issue_addr", mem_addr, 32'h100);
    chk("ld_issue_we", 32'(mem_we), 32'd0);
    chk("c11_pc", if_pc, 32'h14);
    cyc(); #1;
    chk("ld_ack", 32'(dmem_ack), 32'd1);
    chk("ld_rdata", dmem_rdata, 32'hDEAD_BEEF);
    chk("ld_gap_fetch", mem_addr, 32'h20);
    chk("c12_pc", if_pc, 32'h18);
    cyc(); dmem_req = 1'b0; #1;
    chk("c13_ack", 32'(dmem_ack), 32'd0);
    chk("c13_addr", mem_addr, 32'h24);

    cyc();
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h200;
    dmem_wdata = 32'h1234_5678;
    #1;
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    chk("c14_pc", if_pc, 32'h20);
    cyc(); #1;
    chk("st_ack", 32'(dmem_ack), 32'd1);
    chk("c15_addr", mem_addr, 32'h28);
    cyc(); dmem_we = 1'b0; #1;
    chk("st_one_ack", 32'(dmem_ack), 32'd0);
    chk("ld2_addr", mem_addr, 32'h200);
    chk("ld2_we", 32'(mem_we), 32'd0);
    chk("c16_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    chk("ld2_ack", 32'(dmem_ack), 32'd1);
    chk("ld2_rdata", dmem_rdata, 32'h1234_5678);
    chk("c17_pc", if_pc, 32'h28);
    cyc(); dmem_req = 1'b0; fetch_stall = 1'b1; #1;
    chk("ld2_one_ack", 32'(dmem_ack), 32'd0);
    chk("c18_addr", mem_addr, 32'h30);
    chk("c18_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    chk("c19_addr", mem_addr, 32'h34);
    chk("c19_pc", if_pc, 32'h2C);

    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("redir_no_fetch", 32'(mem_en), 32'd0);
    chk("redir_valid_pre", 32'(if_valid), 32'd1);
    cyc(); redirect_valid = 1'b0; fetch_stall = 1'b0; #1;
    chk("redir_flush", 32'(if_valid), 32'd0);
    chk("redir_flush_instr", if_instr, 32'h33);
    chk("redir_fetch", mem_addr, 32'h40);
    chk("redir_fetch_en", 32'(mem_en), 32'd1);
    cyc(); #1;
    chk("redir_r2_valid", 32'(if_valid), 32'd0);
    chk("redir_r2_addr", mem_addr, 32'h44);

    cyc(); fetch_halt = 1'b1; #1;
    chk("redir_r3_pc", if_pc, 32'h40);
    chk("redir_r3_instr", if_instr, 32'h1000_0010);
    chk("halt_en", 32'(mem_en), 32'd0);
    cyc(); #1;
    chk("halt_land_pc", if_pc, 32'h44);
    chk("halt_en2", 32'(mem_en), 32'd0);

    cyc();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h100;
    #1;
    chk("halt_drained", 32'(if_valid), 32'd0);
    chk("halt_data_en", 32'(mem_en), 32'd1);
    chk("halt_data_addr", mem_addr, 32'h100);
    cyc(); RST = 1'b0; #1;
    chk("rstmid_ack", 32'(dmem_ack), 32'd0);
    chk("rstmid_en", 32'(mem_en), 32'd0);
    cyc(); #1;
    chk("rst2_valid", 32'(if_valid), 32'd0);
    chk("rst2_instr", if_instr, 32'h33);
    chk("rst2_pc", if_pc, 32'h0);
    chk("rst2_ack", 32'(dmem_ack), 32'd0);
    chk("rst2_en", 32'(mem_en), 32'd0);
    chk("rst2_we", 32'(mem_we), 32'd0);
    RST = 1'b1; fetch_halt = 1'b0; dmem_req = 1'b0; #1;
    chk("rel_addr", mem_addr, 32'h0);
    chk("rel_en", 32'(mem_en), 32'd1);
    cyc(); #1;
    chk("rel_addr2", mem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
